// File: rtl/psw_pkg.sv
// ---------------------------------------------------------------------------
// psw_pkg
// Shared definitions for the power-switch responder: FSM state encoding and
// the default segment count, settle delay and settle counter width.
// ---------------------------------------------------------------------------
package psw_pkg;

    // Responder states: waiting for a request mismatch, or letting one
    // switch segment settle.
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } psw_state_t;

    localparam int PSW_N_SEG_DEF         = 3;
    localparam int PSW_SETTLE_CYCLES_DEF = 16;
    localparam int PSW_CNT_W_DEF         = 8;

endpackage : psw_pkg

// File: rtl/psw_settle_cnt.sv
// ---------------------------------------------------------------------------
// psw_settle_cnt
// Loadable down-counter that times the settle window of one switch segment.
// A load takes priority over a decrement, and the counter stops at zero.
// o_zero tells the responder that the settle window has run out.
// ---------------------------------------------------------------------------
module psw_settle_cnt
    import psw_pkg::*;
#(
    parameter int CNT_W = PSW_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_dec,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    // Settle counter: load on selection, count down while settling.
    // NOTE: registers are assigned with <= so that every flop samples the
    // values from before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule : psw_settle_cnt

// File: rtl/psw_seq_responder.sv
// ---------------------------------------------------------------------------
// psw_seq_responder
// Switch-end responder of the power-switch handshake. It turns switch
// segments on or off one at a time, waits a settle delay for each, and then
// acknowledges that segment. Segments being powered up take priority over
// segments being powered down. The lowest index goes up first, and the
// highest index goes down first.
//
// Optional feature: define PSW_SETTLE_CFG_EN to add the settle_cfg port.
// The settle count is then taken from that port at each selection edge,
// instead of from the SETTLE_CYCLES parameter.
// ---------------------------------------------------------------------------
module psw_seq_responder
    import psw_pkg::*;
#(
    parameter int N_SEG         = PSW_N_SEG_DEF,
    parameter int SETTLE_CYCLES = PSW_SETTLE_CYCLES_DEF,
    parameter int CNT_W         = PSW_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
`ifdef PSW_SETTLE_CFG_EN
    input  logic [CNT_W-1:0] settle_cfg,
`endif
    input  logic [N_SEG-1:0] pwr_req,
    output logic [N_SEG-1:0] pwr_ack,
    output logic [N_SEG-1:0] sw_en,
    output logic             busy
);

    localparam int SEL_W = (N_SEG > 1) ? $clog2(N_SEG) : 1;

    psw_state_t       r_state;
    logic [SEL_W-1:0] r_sel;
    logic [N_SEG-1:0] r_sw_en;
    logic [N_SEG-1:0] r_ack;

    logic [N_SEG-1:0] w_up;
    logic [N_SEG-1:0] w_dn;
    logic             w_found;
    logic [SEL_W-1:0] w_pick;
    logic [CNT_W-1:0] w_load_val;
    logic             w_load;
    logic             w_dec;
    logic             w_zero;

    // Pick the next segment to switch. Up-candidates override down-candidates.
    // NOTE: every signal gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        w_up    = pwr_req & ~r_ack;
        w_dn    = ~pwr_req & r_ack;
        w_found = 1'b0;
        w_pick  = '0;
        // Rising index: the last hit is the highest down-candidate.
        for (int i = 0; i < N_SEG; i++) begin
            if (w_dn[i]) begin
                w_found = 1'b1;
                w_pick  = SEL_W'(i);
            end
        end
        // Falling index, run second: the last hit is the lowest
        // up-candidate, and it replaces any down pick.
        for (int i = N_SEG - 1; i >= 0; i--) begin
            if (w_up[i]) begin
                w_found = 1'b1;
                w_pick  = SEL_W'(i);
            end
        end
    end

`ifdef PSW_SETTLE_CFG_EN
    // Runtime settle count: a zero setting is treated as one cycle.
    always_comb begin
        w_load_val = (settle_cfg == '0) ? '0 : (settle_cfg - CNT_W'(1));
    end
`else
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    assign w_load_val = SETTLE_LOAD;
`endif

    assign w_load = (r_state == IDLE) && w_found;
    assign w_dec  = (r_state == SETTLE) && !w_zero;

    psw_settle_cnt #(
        .CNT_W (CNT_W)
    ) u_settle_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_dec      (w_dec),
        .i_load_val (w_load_val),
        .o_zero     (w_zero)
    );

    // Handshake FSM. One segment's enable changes on selection. Its
    // acknowledge copies that enable once the settle count runs out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_sw_en <= '0;
            r_ack   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_sel           <= w_pick;
                        r_sw_en[w_pick] <= pwr_req[w_pick];
                        r_state         <= SETTLE;
                    end
                end
                SETTLE: begin
                    // The ack follows the enable, not the request. A request
                    // that reverted mid-settle is reversed later from IDLE.
                    if (w_zero) begin
                        r_ack[r_sel] <= r_sw_en[r_sel];
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign pwr_ack = r_ack;
    assign sw_en   = r_sw_en;
    assign busy    = (r_state == SETTLE);

endmodule : psw_seq_responder

// File: tb/tb_psw_seq_responder.sv
// ---------------------------------------------------------------------------
// tb_psw_seq_responder
// Directed bench for psw_seq_responder with the default parameters
// (3 segments, 16-cycle settle). Inputs change 1 ns after a rising edge.
// Outputs are sampled at the same point, which reflects that edge.
// The settle_cfg cases are compiled in only when PSW_SETTLE_CFG_EN is defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_psw_seq_responder;

    logic       clk;
    logic       rst;
    logic [2:0] pwr_req;
    logic [2:0] pwr_ack;
    logic [2:0] sw_en;
    logic       busy;
`ifdef PSW_SETTLE_CFG_EN
    logic [7:0] settle_cfg;
`endif

    int n_checks;
    int n_errors;

    psw_seq_responder #(
        .N_SEG         (3),
        .SETTLE_CYCLES (16),
        .CNT_W         (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef PSW_SETTLE_CFG_EN
        .settle_cfg (settle_cfg),
`endif
        .pwr_req    (pwr_req),
        .pwr_ack    (pwr_ack),
        .sw_en      (sw_en),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one full 16-cycle settle from IDLE. Checks the enable step, the
    // ack holding its previous value one cycle early, and the ack update.
    task automatic step(input string tag, input logic [2:0] exp_sw,
                        input logic [2:0] prev_ack, input logic [2:0] exp_ack);
        tick();
        check({tag, "_sw"}, 32'(sw_en), 32'(exp_sw));
        check({tag, "_busy"}, 32'(busy), 32'd1);
        repeat (15) tick();
        check({tag, "_ack_early"}, 32'(pwr_ack), 32'(prev_ack));
        tick();
        check({tag, "_ack"}, 32'(pwr_ack), 32'(exp_ack));
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        pwr_req  = 3'b111;
`ifdef PSW_SETTLE_CFG_EN
        settle_cfg = 8'd16;
`endif

        // Reset held for two edges while a request is already pending.
        tick();
        tick();
        check("rst_sw", 32'(sw_en), 32'd0);
        check("rst_ack", 32'(pwr_ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // Full power-up: 001, 011, 111 at 17-cycle spacing.
        step("up0", 3'b001, 3'b000, 3'b001);
        step("up1", 3'b011, 3'b001, 3'b011);
        step("up2", 3'b111, 3'b011, 3'b111);

        // Full power-down: highest segment first.
        pwr_req = 3'b000;
        step("dn2", 3'b011, 3'b111, 3'b011);
        step("dn1", 3'b001, 3'b011, 3'b001);
        step("dn0", 3'b000, 3'b001, 3'b000);
        tick();
        check("quiet_busy", 32'(busy), 32'd0);
        check("quiet_sw", 32'(sw_en), 32'd0);

        // Build up ack=011, then request 100: segment 2 goes up before
        // segments 1 and 0 go down.
        pwr_req = 3'b011;
        step("pa0", 3'b001, 3'b000, 3'b001);
        step("pa1", 3'b011, 3'b001, 3'b011);
        pwr_req = 3'b100;
        step("pri_up2", 3'b111, 3'b011, 3'b111);
        step("pri_dn1", 3'b101, 3'b111, 3'b101);
        step("pri_dn0", 3'b100, 3'b101, 3'b100);

        // Reversal: raise req[0], then drop it 5 cycles into the settle.
        pwr_req = 3'b101;
        tick();
        check("rev_sw_on", 32'(sw_en), 32'b101);
        repeat (5) tick();
        pwr_req = 3'b100;
        repeat (10) tick();
        check("rev_ack_early", 32'(pwr_ack), 32'b100);
        tick();
        check("rev_ack_on", 32'(pwr_ack), 32'b101);
        check("rev_sw_hold", 32'(sw_en), 32'b101);
        tick();
        check("rev_sw_off", 32'(sw_en), 32'b100);
        repeat (15) tick();
        check("rev_ack_hold", 32'(pwr_ack), 32'b101);
        tick();
        check("rev_ack_off", 32'(pwr_ack), 32'b100);

        // Reset while settling, with 7 cycles of settle still to run.
        pwr_req = 3'b111;
        tick();
        check("mid_sw", 32'(sw_en), 32'b101);
        repeat (8) tick();
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_sw", 32'(sw_en), 32'd0);
        check("mid_rst_ack", 32'(pwr_ack), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        step("restart0", 3'b001, 3'b000, 3'b001);
        pwr_req = 3'b001;

`ifdef PSW_SETTLE_CFG_EN
        // settle_cfg = 0 acts as one cycle.
        settle_cfg = 8'd0;
        pwr_req    = 3'b011;
        tick();
        check("cfg0_sw", 32'(sw_en), 32'b011);
        tick();
        check("cfg0_ack", 32'(pwr_ack), 32'b011);
        check("cfg0_idle", 32'(busy), 32'd0);

        // settle_cfg = 3: ack three edges after the enable.
        settle_cfg = 8'd3;
        pwr_req    = 3'b111;
        tick();
        check("cfg3_sw", 32'(sw_en), 32'b111);
        tick();
        tick();
        check("cfg3_early", 32'(pwr_ack), 32'b011);
        tick();
        check("cfg3_ack", 32'(pwr_ack), 32'b111);

        // A settle_cfg change while settling is ignored.
        pwr_req = 3'b011;
        tick();
        check("cfgchg_sw", 32'(sw_en), 32'b011);
        settle_cfg = 8'd20;
        tick();
        tick();
        check("cfgchg_early", 32'(pwr_ack), 32'b111);
        tick();
        check("cfgchg_ack", 32'(pwr_ack), 32'b011);
`endif

        tick();
        check("final_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_psw_seq_responder

// File: doc/psw_seq_responder.md
# psw_seq_responder

Power-switch responder at the switch end of the APC power-switch handshake. It takes per-segment enable requests from the power controller, turns on one switch segment at a time with a settle delay to limit inrush current, and returns a per-segment acknowledge once that segment has settled. It sits in the always-on domain, between the power controller's switch request/acknowledge pins and the switch-cell enable chains of the switchable domain. All signals are active-high "enable" polarity; any sleep-polarity inversion is done at the top level.

## Interface
- N_SEG, 3, number of independently switched segments
- SETTLE_CYCLES, 16, cycles from a switch-enable change to its acknowledge; minimum 1
- CNT_W, 8, settle counter width; SETTLE_CYCLES must be ≤ 2^CNT_W
- clk  in  1  single clock
- rst  in  1  reset; synchronous, active-high
- pwr_req  in  N_SEG  per-segment enable request: 1 = power on, 0 = power off
- pwr_ack  out  N_SEG  per-segment acknowledge; tracks the settled switch state
- sw_en  out  N_SEG  enables to the switch-cell chains
- busy  out  1  high while a segment is settling
- settle_cfg  in  CNT_W  runtime settle count; present only with PSW_SETTLE_CFG_EN

## Operation
- States: IDLE and SETTLE. A registered segment index `sel` and a down-counter `cnt` go with them.
- **Reset:** on any rising edge with rst=1:
  - sw_en=0, pwr_ack=0, busy=0, state=IDLE, cnt=0, sel=0.
  - Reset mid-SETTLE drops all enables on that edge, with no sequencing.
- **Segment selection in IDLE** (evaluated every cycle):
  - Up-candidates are segments with pwr_req=1 and pwr_ack=0. If any exist, pick the lowest such index.
  - Otherwise, down-candidates are segments with pwr_req=0 and pwr_ack=1. If any exist, pick the highest such index.
  - Up always has priority over down. If there is no candidate, stay in IDLE.
- **On selection (IDLE edge):**
  - sw_en[sel] ← pwr_req[sel].
  - cnt ← SETTLE_CYCLES−1.
  - state ← SETTLE.
- **In SETTLE:**
  - If cnt≠0: cnt ← cnt−1.
  - If cnt=0: pwr_ack[sel] ← sw_en[sel], and state ← IDLE.
- Only one segment changes at a time. Other segments' sw_en and pwr_ack are held.
- **Request reversal:** if pwr_req[sel] reverts during SETTLE, the settle still completes. The ack then follows sw_en. The resulting mismatch is picked up in IDLE and reversed with a full settle.
- **Ack invariant:** pwr_ack[i] changes only when state=SETTLE, cnt=0, sel=i. After that update, pwr_ack[i] equals sw_en[i].
- busy is 1 exactly when state=SETTLE.

## Timing
- pwr_req is sampled combinationally in IDLE. The requester must drive it synchronously to clk.
- **Latency for a single request:** if pwr_req[i] changes before edge k (state IDLE):
  - sw_en[i] changes at edge k.
  - pwr_ack[i] changes at edge k+SETTLE_CYCLES.
- After an ack, one IDLE cycle is inserted before the next segment is selected. N segments powering up take N·(SETTLE_CYCLES+1) cycles.
- Requests that arrive while busy wait; none are lost, since selection is level-based.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- PSW_SETTLE_CFG_EN defined:
  - The settle_cfg port exists, and cnt loads max(settle_cfg,1)−1 on selection.
  - settle_cfg is sampled only on the selection edge; changes during SETTLE have no effect.
- PSW_SETTLE_CFG_EN undefined:
  - No settle_cfg port; the SETTLE_CYCLES parameter is used.

## Structure
- Package psw_pkg: state enum (IDLE, SETTLE), default N_SEG, default SETTLE_CYCLES.
- Sub-module psw_settle_cnt: loadable CNT_W down-counter with load, dec, and zero outputs, reset to 0. All other logic is in the top module.

## Test plan
- **Reset:** assert rst for 2 cycles with pwr_req=3'b111 → sw_en=0, pwr_ack=0, busy=0. After release: sw_en=001 at the first edge and pwr_ack=001 16 edges later.
- **Full power-up and power-down:** step pwr_req 000→111.
  - sw_en goes 001, 011, 111 at 17-cycle spacing; pwr_ack follows each step 16 cycles later.
  - Then pwr_req→000: segments go off in order 2, 1, 0.
- **Up priority over down:** pwr_ack=011; set pwr_req=100 → segment 2 turns on first, then segment 1 off, then segment 0 off.
- **Reversal mid-settle:** raise pwr_req[0]; drop it 5 cycles later → pwr_ack[0] rises at cycle 16. sw_en[0] falls the next cycle, and pwr_ack[0] falls 16 cycles after that.
- **Reset mid-SETTLE:** pulse rst at cnt=7 → all outputs are 0 on the next edge; sequencing then restarts from IDLE.
- **With PSW_SETTLE_CFG_EN:** settle_cfg=0 → ack arrives 1 cycle after sw_en. settle_cfg=3 → ack after 3 cycles. Changing settle_cfg mid-SETTLE has no effect.
